// File: rtl/uart_cmd_pkg.sv
// Shared state encoding, frame constants and checksum helper for the UART command receiver.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    S_SYNC,
    S_OPC,
    S_DHI,
    S_DLO,
    S_CHK
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // A frame is good when its four post-sync bytes sum to zero modulo 256.
  function automatic logic sum_is_zero(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d);
    logic [7:0] s;
    s = a + b + c + d;
    return (s == 8'h00);
  endfunction

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter: expired is high while count sits at TIMEOUT_CYCLES-1.
// No backpressure; clr has priority over en and the count saturates once expired.
module uart_cmd_timer #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_cmd_rx.sv
// Parses SYNC/OPC/DHI/DLO/CHK frames from a UART byte stream into a held command.
// Command and error flags appear one cycle after the CHK byte; every byte is consumed on sight.
module uart_cmd_rx
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_byte,
  output logic        clr_rx_rdy,
  input  logic        clr_cmd_rdy,
  output logic        cmd_rdy,
  output logic [7:0]  opcode,
  output logic [15:0] payload,
  output logic        chk_err,
  output logic        to_err,
  output logic        ovr_err
);

  state_t     state;
  logic [7:0] hold_opc;
  logic [7:0] hold_dhi;
  logic [7:0] hold_dlo;
  logic       expired;
  logic       frame_ok;
  logic       in_frame;

  assign clr_rx_rdy = rx_rdy;
  assign in_frame   = (state != S_SYNC);
  assign frame_ok   = sum_is_zero(hold_opc, hold_dhi, hold_dlo, rx_byte);

  uart_cmd_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (rx_rdy || !in_frame),
    .en     (in_frame),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_SYNC;
      hold_opc <= '0;
      hold_dhi <= '0;
      hold_dlo <= '0;
      cmd_rdy  <= 1'b0;
      opcode   <= '0;
      payload  <= '0;
      chk_err  <= 1'b0;
      to_err   <= 1'b0;
      ovr_err  <= 1'b0;
    end else begin
      chk_err <= 1'b0;
      to_err  <= 1'b0;
      ovr_err <= 1'b0;
      // A set later in this block overrides the acknowledge.
      if (clr_cmd_rdy) cmd_rdy <= 1'b0;

      if (rx_rdy) begin
        case (state)
          S_SYNC: if (rx_byte == SYNC_BYTE) state <= S_OPC;
          S_OPC: begin
            hold_opc <= rx_byte;
            state    <= S_DHI;
          end
          S_DHI: begin
            hold_dhi <= rx_byte;
            state    <= S_DLO;
          end
          S_DLO: begin
            hold_dlo <= rx_byte;
            state    <= S_CHK;
          end
          S_CHK: begin
            state <= S_SYNC;
            if (frame_ok) begin
              opcode  <= hold_opc;
              payload <= {hold_dhi, hold_dlo};
              cmd_rdy <= 1'b1;
              ovr_err <= cmd_rdy && !clr_cmd_rdy;
            end else begin
              chk_err <= 1'b1;
            end
          end
          default: state <= S_SYNC;
        endcase
      end else if (expired && in_frame) begin
        state    <= S_SYNC;
        hold_opc <= '0;
        hold_dhi <= '0;
        hold_dlo <= '0;
        to_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed and randomized bench for uart_cmd_rx against a byte-queue frame model.
module tb_uart_cmd_rx;

  localparam int         TO = 64;
  localparam logic [7:0] SB = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        clr_cmd_rdy = 1'b0;
  logic        clr_rx_rdy;
  logic        cmd_rdy;
  logic [7:0]  opcode;
  logic [15:0] payload;
  logic        chk_err;
  logic        to_err;
  logic        ovr_err;

  int checks = 0;
  int fails = 0;
  int chk_cnt = 0;
  int to_cnt = 0;
  int ovr_cnt = 0;

  // Reference model: bytes of the frame collected so far (empty = hunting for sync).
  logic [7:0]  q[$];
  int          idle;
  logic        m_rdy;
  logic [7:0]  m_opc;
  logic [15:0] m_pay;
  logic        m_chk;
  logic        m_to;
  logic        m_ovr;

  always #5 clk = ~clk;

  uart_cmd_rx #(
    .SYNC_BYTE     (SB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_rdy     (rx_rdy),
    .rx_byte    (rx_byte),
    .clr_rx_rdy (clr_rx_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .cmd_rdy    (cmd_rdy),
    .opcode     (opcode),
    .payload    (payload),
    .chk_err    (chk_err),
    .to_err     (to_err),
    .ovr_err    (ovr_err)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    idle  = 0;
    m_rdy = 1'b0;
    m_opc = 8'h00;
    m_pay = 16'h0000;
    m_chk = 1'b0;
    m_to  = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b, input logic clr);
    logic set;
    int   s;
    set   = 1'b0;
    m_chk = 1'b0;
    m_to  = 1'b0;
    m_ovr = 1'b0;
    if (v) begin
      idle = 0;
      if (q.size() == 0) begin
        if (b == SB) q.push_back(b);
      end else begin
        q.push_back(b);
        if (q.size() == 5) begin
          s = int'(q[1]) + int'(q[2]) + int'(q[3]) + int'(q[4]);
          if (s % 256 == 0) begin
            set   = 1'b1;
            m_ovr = m_rdy && !clr;
            m_opc = q[1];
            m_pay = {q[2], q[3]};
          end else begin
            m_chk = 1'b1;
          end
          q.delete();
        end
      end
    end else if (q.size() != 0) begin
      idle++;
      if (idle == TO) begin
        q.delete();
        idle = 0;
        m_to = 1'b1;
      end
    end
    if (set) m_rdy = 1'b1;
    else if (clr) m_rdy = 1'b0;
  endtask

  // Entered and left at a falling edge; one clk period per call.
  task automatic cycle(input logic v, input logic [7:0] b, input logic clr);
    rx_rdy      = v;
    rx_byte     = b;
    clr_cmd_rdy = clr;
    #1;
    check("clr_rx_rdy", 16'(clr_rx_rdy), 16'(v));
    @(posedge clk);
    model_step(v, b, clr);
    @(negedge clk);
    check("cmd_rdy", 16'(cmd_rdy), 16'(m_rdy));
    check("opcode", 16'(opcode), 16'(m_opc));
    check("payload", payload, m_pay);
    check("chk_err", 16'(chk_err), 16'(m_chk));
    check("to_err", 16'(to_err), 16'(m_to));
    check("ovr_err", 16'(ovr_err), 16'(m_ovr));
    if (chk_err === 1'b1) chk_cnt++;
    if (to_err === 1'b1) to_cnt++;
    if (ovr_err === 1'b1) ovr_cnt++;
    rx_rdy      = 1'b0;
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b1, b, 1'b0);
  endtask

  task automatic idle_n(input int n, input logic clr);
    repeat (n) cycle(1'b0, 8'h00, clr);
  endtask

  task automatic send_frame(input logic [7:0] o, input logic [7:0] h, input logic [7:0] l,
                            input logic [7:0] c, input logic clr_last);
    send(SB);
    send(o);
    send(h);
    send(l);
    cycle(1'b1, c, clr_last);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    rx_rdy      = 1'b1;
    rx_byte     = 8'h34;
    clr_cmd_rdy = 1'b0;
    #1;
    check("rst_clr_rx_rdy", 16'(clr_rx_rdy), 16'd1);
    check("rst_cmd_rdy", 16'(cmd_rdy), 16'd0);
    check("rst_opcode", 16'(opcode), 16'd0);
    check("rst_payload", payload, 16'd0);
    check("rst_pulses", {13'd0, chk_err, to_err, ovr_err}, 16'd0);
    repeat (2) @(negedge clk);
    rx_rdy = 1'b0;
    rst_n  = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [7:0] o, h, l, c;
    int         s;
    int         mode;
    logic [7:0] fb[5];

    model_reset();
    @(negedge clk);
    do_reset();

    // Basic valid frame, then acknowledge.
    send_frame(8'h10, 8'h12, 8'h34, 8'hAA, 1'b0);
    check("valid_cmd_rdy", 16'(cmd_rdy), 16'd1);
    check("valid_opcode", 16'(opcode), 16'h0010);
    check("valid_payload", payload, 16'h1234);
    idle_n(1, 1'b1);
    check("ack_cmd_rdy", 16'(cmd_rdy), 16'd0);

    // Bad checksum leaves the held command alone.
    chk_cnt = 0;
    send_frame(8'h10, 8'h12, 8'h34, 8'hAB, 1'b0);
    idle_n(2, 1'b0);
    check("bad_chk_pulses", 16'(chk_cnt), 16'd1);
    check("bad_cmd_rdy", 16'(cmd_rdy), 16'd0);
    check("bad_payload", payload, 16'h1234);

    // Leading garbage before sync.
    send(8'h00);
    send(8'hFF);
    send_frame(8'h01, 8'h00, 8'h00, 8'hFF, 1'b0);
    check("garbage_opcode", 16'(opcode), 16'h0001);
    check("garbage_payload", payload, 16'h0000);
    idle_n(1, 1'b1);

    // Timeout after two bytes, then recovery.
    to_cnt = 0;
    send(SB);
    send(8'h10);
    idle_n(TO, 1'b0);
    check("timeout_pulses", 16'(to_cnt), 16'd1);
    send_frame(8'h10, 8'h12, 8'h34, 8'hAA, 1'b0);
    check("post_to_cmd_rdy", 16'(cmd_rdy), 16'd1);
    idle_n(1, 1'b1);

    // Gaps one cycle short of the timeout: byte wins.
    send(SB);
    idle_n(TO - 1, 1'b0);
    send(8'h10);
    idle_n(TO - 1, 1'b0);
    send(8'h12);
    send(8'h34);
    send(8'hAA);
    check("edge_to_pulses", 16'(to_cnt), 16'd1);
    check("edge_cmd_rdy", 16'(cmd_rdy), 16'd1);
    idle_n(1, 1'b1);

    // Sync byte value inside a frame is data.
    send_frame(SB, SB, SB, 8'h11, 1'b0);
    check("sync_data_payload", payload, 16'hA5A5);
    idle_n(1, 1'b1);

    // Overwrite without ack, then set-wins against a same-cycle ack.
    ovr_cnt = 0;
    send_frame(8'h01, 8'h02, 8'h03, 8'hFA, 1'b0);
    send_frame(8'h04, 8'h05, 8'h06, 8'hF1, 1'b0);
    check("ovr_pulses", 16'(ovr_cnt), 16'd1);
    check("ovr_payload", payload, 16'h0506);
    send_frame(8'h07, 8'h08, 8'h09, 8'hE8, 1'b1);
    check("set_wins_cmd_rdy", 16'(cmd_rdy), 16'd1);
    check("set_wins_ovr", 16'(ovr_cnt), 16'd1);
    idle_n(1, 1'b1);

    // Reset mid-frame discards the partial frame and stray bytes.
    send(SB);
    send(8'h10);
    send(8'h12);
    do_reset();
    send(8'h34);
    send(8'hAA);
    send_frame(8'h20, 8'h00, 8'h01, 8'hDF, 1'b0);
    check("rst_frame_opcode", 16'(opcode), 16'h0020);
    check("rst_frame_payload", payload, 16'h0001);

    // Random frames with garbage, bad checksums, long gaps and random acks.
    for (int f = 0; f < 150; f++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        o = 8'($urandom);
        if (o == SB) o = 8'h00;
        send(o);
      end
      o = 8'($urandom);
      h = 8'($urandom);
      l = 8'($urandom);
      s = int'(o) + int'(h) + int'(l);
      c = 8'((256 - s % 256) % 256);
      if ($urandom_range(0, 3) == 0) c = c + 8'($urandom_range(1, 255));
      fb[0] = SB;
      fb[1] = o;
      fb[2] = h;
      fb[3] = l;
      fb[4] = c;
      for (int k = 0; k < 5; k++) begin
        cycle(1'b1, fb[k], $urandom_range(0, 5) == 0);
        mode = int'($urandom_range(0, 15));
        if (mode == 0) idle_n(TO, 1'b0);
        else if (mode == 1) idle_n(TO - 1, 1'b0);
        else begin
          for (int g = 0; g < int'($urandom_range(0, 3)); g++)
            cycle(1'b0, 8'h00, $urandom_range(0, 5) == 0);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_cmd_rx.md
UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, value of the frame-start byte.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096, maximum clk cycles allowed between bytes inside a frame.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rx_rdy  input  1  byte-valid from the UART receiver; held high until cleared.
REQ-006 rx_byte  input  8  received byte; valid while rx_rdy=1.
REQ-007 clr_rx_rdy  output  1  consume strobe back to the receiver's clr_rdy.
REQ-008 clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy.
REQ-009 cmd_rdy  output  1  a validated command is held on opcode and payload.
REQ-010 opcode  output  8  command opcode of the last valid frame.
REQ-011 payload  output  16  command data of the last valid frame, {DHI,DLO}.
REQ-012 chk_err  output  1  one-cycle pulse when a frame fails checksum.
REQ-013 to_err  output  1  one-cycle pulse when a frame is abandoned on timeout.
REQ-014 ovr_err  output  1  one-cycle pulse when a valid frame overwrites an unacknowledged command.

Function
REQ-015 Frame format: SYNC_BYTE, OPC, DHI, DLO, CHK, in that order.
REQ-016 clr_rx_rdy is combinational, equals rx_rdy; each byte is consumed exactly once, in the cycle rx_rdy is first seen high.
REQ-017 FSM states are SYNC, OPC, DHI, DLO, CHK; the state advances only on a consumed byte.
REQ-018 SYNC: byte == SYNC_BYTE -> OPC; any other byte is discarded and the state stays SYNC.
REQ-019 OPC, DHI, DLO: the byte is stored in an internal hold register and the state advances to DHI, DLO, CHK respectively.
REQ-020 CHK: the frame is valid when (OPC+DHI+DLO+CHK) mod 256 == 0, using 8-bit wrap-around sum; the state always returns to SYNC.
REQ-021 Valid frame: opcode and payload load from the hold registers on the consuming edge; cmd_rdy=1 from the next cycle.
REQ-022 Invalid frame: opcode, payload and cmd_rdy are unchanged; chk_err=1 for exactly the next cycle.
REQ-023 cmd_rdy stays high until clr_cmd_rdy is sampled high; a set and a clear in the same cycle leave cmd_rdy=1 (set wins).
REQ-024 Valid frame while cmd_rdy=1 and clr_cmd_rdy=0: outputs are overwritten and ovr_err pulses for one cycle.
REQ-025 Timeout counter: cleared on every consumed byte and held at 0 in SYNC; it increments each cycle in OPC..CHK.
REQ-026 Counter reaching TIMEOUT_CYCLES-1 with no byte in that cycle: the state goes to SYNC, hold registers are discarded, and to_err pulses for one cycle.
REQ-027 A byte arriving in the same cycle the timeout expires is consumed normally (byte wins); no timeout occurs.
REQ-028 A SYNC_BYTE value received in OPC..CHK is treated as data, not as a resync.
REQ-029 Latency: last CHK byte consumed at edge N -> cmd_rdy/chk_err high from N+1.

Reset
REQ-030 rst_n low forces the state to SYNC, the counter to 0, cmd_rdy=0, opcode=0, payload=0, chk_err=0, to_err=0, ovr_err=0, and the hold registers to 0.
REQ-031 Reset mid-frame discards the partial frame; the first byte after release is evaluated in SYNC.
REQ-032 clr_rx_rdy follows rx_rdy even during reset; no other output depends on inputs while rst_n=0.

Structure
REQ-033 The state enum (SYNC..CHK) and the SYNC_BYTE default live in a shared package, uart_cmd_pkg.
REQ-034 One sub-module, uart_cmd_timer, holds the timeout counter (inputs: clr, en; output: expired); everything else is flat.

Verification
REQ-035 Send A5 10 12 34 AA (sum 0x00): cmd_rdy=1, opcode=10, payload=1234, chk_err=0.
REQ-036 Send A5 10 12 34 AB: chk_err pulses once, cmd_rdy stays 0, opcode/payload unchanged.
REQ-037 Send 00 FF A5 01 00 00 FF: the leading bytes are discarded; cmd_rdy=1, opcode=01, payload=0000.
REQ-038 Send A5 10, then idle TIMEOUT_CYCLES cycles: to_err pulses once; a following full valid frame is accepted.
REQ-039 Send two valid frames without clr_cmd_rdy: ovr_err pulses once and the outputs hold the second frame; clr_cmd_rdy in the cycle of the second frame's set keeps cmd_rdy=1.
REQ-040 Assert rst_n low after A5 10 12, then send 34 AA A5 20 00 01 DF: the stray bytes are discarded; cmd_rdy=1, opcode=20, payload=0001.
